// File: rtl/gaussian_pyramid_scheduler_if.sv
// gaussian_pyramid_scheduler_if: control and blur-engine handshake bundle (perf_cycles present when SCHED_PERF_CNT_EN is defined)
interface gaussian_pyramid_scheduler_if;
   logic        start;
   logic        abort;
   logic        blur_start;
   logic        blur_valid;
   logic        blur_done;
   logic [1:0]  src_sel;
   logic [1:0]  dst_sel;
   logic        downsample_en;
   logic [1:0]  octave_idx;
   logic [2:0]  scale_idx;
   logic        busy;
   logic        done;
   logic        err_timeout;
   logic        err_count;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif
   modport master (
      input  start, abort, blur_valid, blur_done,
      output blur_start, src_sel, dst_sel, downsample_en, octave_idx, scale_idx,
             busy, done, err_timeout, err_count
`ifdef SCHED_PERF_CNT_EN
      , output perf_cycles
`endif
   );
   modport slave (
      output start, abort, blur_valid, blur_done,
      input  blur_start, src_sel, dst_sel, downsample_en, octave_idx, scale_idx,
             busy, done, err_timeout, err_count
`ifdef SCHED_PERF_CNT_EN
      , input perf_cycles
`endif
   );
endinterface

// File: rtl/gaussian_pyramid_scheduler.sv
// gaussian_pyramid_scheduler: sequences blur passes over octaves/scales, ping-pongs frame buffers, checks pixel counts; SCHED_PERF_CNT_EN adds a busy-cycle counter
module gaussian_pyramid_scheduler #(
   parameter int WIDTH          = 128,
   parameter int HEIGHT         = 128,
   parameter int NUM_OCTAVES    = 2,
   parameter int NUM_SCALES     = 5,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input logic clk,
   input logic rst,
   gaussian_pyramid_scheduler_if.master bus_if
);
   localparam int PIX_W = $clog2(WIDTH * HEIGHT) + 1;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0]      LAST_OCT = 2'(NUM_OCTAVES - 1);
   localparam logic [2:0]      LAST_SCL = 3'(NUM_SCALES - 1);
   localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_DONE, S_ERROR} state_t;

   state_t           state_q;
   logic [PIX_W-1:0] pix_q, pix_d, pix_exp;
   logic [WD_W-1:0]  wd_q;
   logic [1:0]       octave_q, octave_d, src_q, dst_q;
   logic [2:0]       scale_q, scale_d;
   logic             ds_q, ds_d, blur_start_q, busy_q, done_q, err_to_q, err_cnt_q, last_pass;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0]      perf_q;
`endif

   // next pass indices, saturating pixel increment and expected pixel count of the current octave
   always_comb begin
      scale_d   = (scale_q == LAST_SCL) ? 3'd0 : scale_q + 3'd1;
      octave_d  = (scale_q == LAST_SCL) ? octave_q + 2'd1 : octave_q;
      ds_d      = (scale_d == 3'd0) && (octave_d != 2'd0);
      last_pass = (scale_q == LAST_SCL) && (octave_q == LAST_OCT);
      pix_d     = (&pix_q) ? pix_q : pix_q + 1'b1;
      pix_exp   = PIX_W'((WIDTH >> octave_q) * (HEIGHT >> octave_q));
   end

   // control FSM with registered outputs; abort overrides every transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pix_q        <= '0;
         wd_q         <= '0;
         octave_q     <= '0;
         scale_q      <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         ds_q         <= 1'b0;
         blur_start_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_to_q     <= 1'b0;
         err_cnt_q    <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
         perf_q       <= '0;
`endif
      end else begin
         blur_start_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
         if (busy_q) perf_q <= perf_q + 32'd1;
`endif
         if (bus_if.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: if (bus_if.start) begin
                  state_q   <= S_LAUNCH;
                  busy_q    <= 1'b1;
                  pix_q     <= '0;
                  wd_q      <= '0;
                  octave_q  <= '0;
                  scale_q   <= '0;
                  src_q     <= 2'd0;
                  dst_q     <= 2'd1;
                  ds_q      <= 1'b0;
                  err_to_q  <= 1'b0;
                  err_cnt_q <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
                  perf_q    <= '0;
`endif
               end
               S_LAUNCH: begin
                  blur_start_q <= 1'b1;
                  pix_q        <= '0;
                  wd_q         <= '0;
                  state_q      <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus_if.blur_valid) pix_q <= pix_d;
                  wd_q <= wd_q + 1'b1;
                  if (bus_if.blur_done) state_q <= S_CHECK;
                  else if (wd_q == WD_LAST) begin
                     err_to_q <= 1'b1;
                     state_q  <= S_ERROR;
                  end
               end
               S_CHECK: begin
                  if (pix_q != pix_exp) err_cnt_q <= 1'b1;
                  if (last_pass) state_q <= S_DONE;
                  else begin
                     scale_q  <= scale_d;
                     octave_q <= octave_d;
                     ds_q     <= ds_d;
                     src_q    <= dst_q;
                     dst_q    <= (dst_q == 2'd1) ? 2'd2 : 2'd1;
                     state_q  <= S_LAUNCH;
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_ERROR;
            endcase
         end
      end
   end

   assign bus_if.blur_start    = blur_start_q;
   assign bus_if.src_sel       = src_q;
   assign bus_if.dst_sel       = dst_q;
   assign bus_if.downsample_en = ds_q;
   assign bus_if.octave_idx    = octave_q;
   assign bus_if.scale_idx     = scale_q;
   assign bus_if.busy          = busy_q;
   assign bus_if.done          = done_q;
   assign bus_if.err_timeout   = err_to_q;
   assign bus_if.err_count     = err_cnt_q;
`ifdef SCHED_PERF_CNT_EN
   assign bus_if.perf_cycles   = perf_q;
`endif
endmodule
